// File: rtl/seq_fixed_multiplier.sv
// Signed fixed-point multiplier, one shift-add iteration per clock, valid/ready on both sides.
// Optional `MULT_SAT_EN`: clamp result on overflow instead of wrapping.
module seq_fixed_multiplier #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    // Handshake: a beat moves on any rising edge where valid && ready are both high;
    // valid never waits on ready, and the producer holds its data until the beat moves.

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [PW-1:0]    r_acc;
    logic [PW-1:0]    r_mcand;
    logic [WIDTH-1:0] r_mplr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sign;
    logic [WIDTH-1:0] r_result;
    logic             r_ovf;

    logic                 w_accept;
    logic                 w_iter_done;
    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic signed [PW-1:0] w_prod;
    logic signed [PW-1:0] w_scaled;
    logic [WIDTH:0]       w_hi;
    logic                 w_ovf;
    logic [WIDTH-1:0]     w_res;

    assign w_accept    = in_valid && (r_state == S_IDLE);
    assign w_iter_done = (r_cnt == CNT_W'(WIDTH));

    // Negating the most negative value wraps to 2^(WIDTH-1), which is exact as unsigned.
    assign w_mag_a = a[WIDTH-1] ? -a : a;
    assign w_mag_b = b[WIDTH-1] ? -b : b;

    assign w_prod   = signed'(r_sign ? -r_acc : r_acc);
    assign w_scaled = w_prod >>> FRAC;

    // The scaled value fits only if its top WIDTH+1 bits are a pure sign extension.
    assign w_hi  = w_scaled[PW-1:WIDTH-1];
    assign w_ovf = ~((&w_hi) | ~(|w_hi));

`ifdef MULT_SAT_EN
    always_comb begin
        w_res = w_scaled[WIDTH-1:0];
        if (w_ovf) begin
            w_res = w_scaled[PW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign w_res = w_scaled[WIDTH-1:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_BUSY;
            S_BUSY:  if (w_iter_done) w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplr   <= '0;
            r_cnt    <= '0;
            r_sign   <= 1'b0;
            r_result <= '0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_acc   <= '0;
                        r_mcand <= {{WIDTH{1'b0}}, w_mag_a};
                        r_mplr  <= w_mag_b;
                        r_cnt   <= '0;
                        r_sign  <= a[WIDTH-1] ^ b[WIDTH-1];
                    end
                end
                S_BUSY: begin
                    if (!w_iter_done) begin
                        if (r_mplr[0]) begin
                            r_acc <= r_acc + r_mcand;
                        end
                        r_mcand <= r_mcand << 1;
                        r_mplr  <= r_mplr >> 1;
                        r_cnt   <= r_cnt + CNT_W'(1);
                    end else begin
                        r_result <= w_res;
                        r_ovf    <= w_ovf;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign result    = r_result;
    assign ovf       = r_ovf;
    assign dbg_state = r_state;

endmodule
